// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank
// Performance-counter bank that sits beside the processor pipeline. It
// counts cycles plus NUM_EVENTS single-bit event strobes while running,
// freezes on halt, and exposes every counter through a registered
// select/read port with one cycle of latency.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   enable    counting permitted while high (IDLE <-> RUN)
//   clear     synchronous clear of counters and overflow flags, forces IDLE
//   halt      processor halt strobe (RUN -> HALTED)
//   event_in  per-channel event strobes, channel i counts event_in[i]
//   rd_req    read request
//   rd_sel    0 = cycle counter, k = event channel k-1
//   rd_valid  rd_data / rd_err valid this cycle
//   rd_data   selected counter value (pre-increment at the request edge)
//   rd_err    rd_sel was out of range
//   ovf       sticky overflow flags, bit 0 = cycle, bit k = channel k-1
//   state     00 IDLE, 01 RUN, 10 HALTED
//   halted    state == HALTED
module perf_event_counter_bank #(
  parameter int NUM_EVENTS = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_WIDTH  = 3,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  halt,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  rd_req,
  input  logic [SEL_WIDTH-1:0]  rd_sel,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_err,
  output logic [NUM_EVENTS:0]   ovf,
  output logic [1:0]            state,
  output logic                  halted
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] HALTED = 2'b10;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [SEL_WIDTH-1:0] MAX_SEL  = SEL_WIDTH'(NUM_EVENTS);

  logic [1:0]           next_state;
  logic                 counting;
  logic [NUM_EVENTS:0]  inc;
  logic [CNT_WIDTH-1:0] cnt [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] sel_value;

  // Index 0 is the cycle counter, which increments on every counting edge.
  assign inc      = {event_in, 1'b1};
  // The halt edge and the RUN->IDLE edge still count because state is RUN there.
  assign counting = (state == RUN) && !clear;

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = enable ? RUN : IDLE;
        RUN: begin
          if (halt) begin
            next_state = HALTED;
          end else if (!enable) begin
            next_state = IDLE;
          end else begin
            next_state = RUN;
          end
        end
        HALTED:  next_state = HALTED;
        default: next_state = IDLE;
      endcase
    end
  end

  // State register with a registered halted flag that tracks the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      state  <= next_state;
      halted <= (next_state == HALTED);
    end
  end

  // Counters and sticky overflow flags; wrap or saturate on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NUM_EVENTS; k++) begin
        cnt[k] <= CNT_ZERO;
      end
      ovf <= {(NUM_EVENTS+1){1'b0}};
    end else if (clear) begin
      for (int k = 0; k <= NUM_EVENTS; k++) begin
        cnt[k] <= CNT_ZERO;
      end
      ovf <= {(NUM_EVENTS+1){1'b0}};
    end else if (counting) begin
      for (int k = 0; k <= NUM_EVENTS; k++) begin
        if (inc[k]) begin
          if (cnt[k] == CNT_MAX) begin
            ovf[k] <= 1'b1;
            cnt[k] <= (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
          end else begin
            cnt[k] <= cnt[k] + CNT_ONE;
          end
        end
      end
    end
  end

  // Read-port mux over the current (pre-increment) counter values.
  always_comb begin
    sel_value = CNT_ZERO;
    for (int k = 0; k <= NUM_EVENTS; k++) begin
      sel_value = (rd_sel == SEL_WIDTH'(k)) ? cnt[k] : sel_value;
    end
  end

  // Registered read response; rd_data holds between requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= CNT_ZERO;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_sel > MAX_SEL) begin
          rd_data <= CNT_ZERO;
          rd_err  <= 1'b1;
        end else begin
          rd_data <= sel_value;
          rd_err  <= 1'b0;
        end
      end else begin
        rd_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
Synthesizable, parametrised performance-counter bank that moves the bench-side instruction/cache-hit/request tallies into the design itself. It sits beside the pipeline in proc_hier. It counts cycles plus NUM_EVENTS single-bit event strobes (retire, ICacheReq, ICacheHit, DCacheReq, DCacheHit, …) and freezes on Halt. Counters are readable through a registered select/read port, so both the bench and future debug logic can sample them.

Parameters:
NUM_EVENTS, 5, number of event channels; channel i counts event_in[i].
CNT_WIDTH, 32, width of every counter, including the cycle counter.
SEL_WIDTH, 3, width of rd_sel; must satisfy 2^SEL_WIDTH >= NUM_EVENTS+1.
SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  counting permitted while high
clear  in  1  synchronous clear of all counters and overflow flags
halt  in  1  processor halt strobe
event_in  in  NUM_EVENTS  per-channel event strobes, sampled at posedge clk
rd_req  in  1  read request
rd_sel  in  SEL_WIDTH  0 = cycle counter; k = event channel k-1 (k = 1..NUM_EVENTS)
rd_valid  out  1  rd_data/rd_err valid this cycle
rd_data  out  CNT_WIDTH  selected counter value
rd_err  out  1  rd_sel out of range
ovf  out  NUM_EVENTS+1  sticky overflow flags; bit 0 = cycle counter, bit k = channel k-1
state  out  2  00 IDLE, 01 RUN, 10 HALTED
halted  out  1  state == HALTED

Behaviour:
- Reset (async, rst=1): all counters 0; ovf 0; state IDLE; rd_valid 0; rd_data 0; rd_err 0; halted 0. Reset mid-operation discards all counts immediately, without waiting for a clock edge.
- FSM, evaluated at posedge clk. clear has priority over every other transition.
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 and halt=0.
  - RUN -> HALTED when halt=1, regardless of enable.
  - HALTED -> IDLE on clear=1. enable does not leave HALTED.
  - Any state with clear=1 -> IDLE, counters and ovf zeroed.
- Counting occurs only on an edge where state==RUN and clear=0.
  - Cycle counter increments by 1.
  - Each channel i increments by 1 iff event_in[i]=1.
  - The halt edge itself is counted: its cycle and its events are included, so the halt instruction contributes to the retire count.
  - In IDLE and HALTED all counters hold.
- Clear in the same cycle as events: clear wins, and counters are 0 after the edge.
- Overflow, when a counter at all-ones would increment:
  - SATURATE=1: value stays all-ones.
  - SATURATE=0: value becomes 0.
  - In both modes the matching ovf bit sets and stays set until clear or rst.
- Read port, 1-cycle latency:
  - rd_req=1 at edge t loads rd_data with the selected counter's value before edge t's increment, and sets rd_valid=1 for the cycle after t.
  - rd_req=0 gives rd_valid=0; rd_data holds its last value.
  - rd_sel > NUM_EVENTS gives rd_data=0, rd_err=1, rd_valid=1.
  - rd_err=0 on every valid in-range read.
  - Reads are legal in every state, back-to-back every cycle, and do not disturb counting.
  - A read on the clear edge returns the pre-clear value.
- event_in is ignored outside RUN. halt in IDLE or HALTED is ignored.
- Arithmetic is unsigned, CNT_WIDTH bits. No counter ever exceeds CNT_WIDTH bits.

Test Plan:
1. Reset, then enable=1 for 10 cycles with event_in=5'b00001 every cycle and 5'b00100 on 3 of them; read sel 0,1,3 -> 10, 10, 3; rd_err=0.
2. RUN for 4 cycles, then halt=1 with event_in[0]=1 on the 5th edge -> state=HALTED, cycle=5, ch0 includes the halt edge; 20 further cycles with events -> counts unchanged; clear -> all 0, state IDLE.
3. CNT_WIDTH=4, SATURATE=1, 18 events on ch1 -> rd_data=4'hF, ovf[2]=1; rebuild with SATURATE=0, 18 events -> rd_data=4'h2, ovf[2]=1.
4. clear and event_in=5'b11111 on the same edge in RUN -> all counters 0 next cycle; a read issued on that edge returns the pre-clear value.
5. rd_sel=7 with NUM_EVENTS=5 -> rd_valid=1, rd_err=1, rd_data=0; back-to-back reads sel 0,1,2 -> three consecutive valid cycles, each one cycle after its request.
6. Assert rst asynchronously mid-cycle while in RUN with counts nonzero -> outputs zero before the next clk edge; state IDLE.
